// File: rtl/instr_fetch_ir_pkg.sv
// Shared types and constants for the fetch / instruction-register stage.
// Package if_pkg is imported by the fetch top, its buffer and its bus interface.
package if_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int BUF_DEPTH = 2;

    // Address the PC stage starts from after reset.
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } ir_entry_t;

endpackage

// File: rtl/instr_fetch_ir_if.sv
// Bus bundle around the fetch stage: PC handshake, memory read port,
// decode handshake and flush. master = fetch stage, slave = its environment.
interface instr_fetch_ir_if;
    import if_pkg::*;

    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic              flush;

    modport master (
        input  pc_addr, pc_valid, mem_rdata, ir_ready, flush,
        output pc_ready, mem_rd, mem_addr, ir_valid, ir_data, ir_pc
    );

    modport slave (
        output pc_addr, pc_valid, mem_rdata, ir_ready, flush,
        input  pc_ready, mem_rd, mem_addr, ir_valid, ir_data, ir_pc
    );

endinterface

// File: rtl/instr_fetch_ir_skid_buf.sv
// Two-entry instruction buffer. The head entry is a register of its own so
// the decode-facing outputs come straight from flops; the tail shifts into
// the head on pop. clear has priority over push and pop.
module ir_skid_buf
    import if_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  ir_entry_t din,
    output logic [1:0] count,
    output ir_entry_t head
);

    logic [1:0] count_reg;
    ir_entry_t  head_reg;
    ir_entry_t  tail_reg;
    logic       pop_ok;
    logic       push_ok;

    // A push into a full buffer is only taken when the head leaves the same cycle.
    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'(BUF_DEPTH)) || pop_ok);

    // Buffer storage and occupancy update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 2'd0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else if (clear) begin
            count_reg <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_reg == 2'd0) head_reg <= din;
                    else                   tail_reg <= din;
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        head_reg <= din;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/instr_fetch_ir.sv
// Fetch / instruction-register stage: accepts PC addresses, issues reads to a
// one-cycle synchronous instruction memory, pairs each returned word with its
// PC in a 2-entry buffer and hands entries to decode. flush discards buffered
// entries and the in-flight response.
// Optional macro IF_PERF_CNT_EN adds the stall_cnt output (saturating count of
// cycles where the PC stage offered an address that was not accepted).
module instr_fetch_ir
    import if_pkg::*;
(
    input  logic clk,
    input  logic rst,
    instr_fetch_ir_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    logic [1:0]        count;
    ir_entry_t         head;
    ir_entry_t         din;
    logic              ready_en_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] pend_pc_reg;
    fetch_state_e      state_reg;
    fetch_state_e      state_next;
    logic [1:0]        occ;
    logic [1:0]        cnt_next;
    logic [1:0]        occ_next;
    logic              pop;
    logic              push;
    logic              accept;
    logic              pc_ready_int;

    // Occupancy counts the outstanding read so a full buffer is never overrun.
    assign occ          = count + {1'b0, inflight_reg};
    assign pop          = (count != 2'd0) && bus.ir_ready;
    assign pc_ready_int = ready_en_reg && !bus.flush &&
                          ((occ < 2'(BUF_DEPTH)) || ((occ == 2'(BUF_DEPTH)) && pop));
    assign accept       = bus.pc_valid && pc_ready_int;
    // The response of a flushed fetch is never written.
    assign push         = inflight_reg && !bus.flush && (state_reg != S_DROP);
    assign din          = '{pc: pend_pc_reg, data: bus.mem_rdata};

    assign bus.pc_ready = pc_ready_int;
    assign bus.mem_rd   = accept;
    assign bus.mem_addr = accept ? bus.pc_addr : '0;
    assign bus.ir_valid = (count != 2'd0);
    assign bus.ir_data  = head.data;
    assign bus.ir_pc    = head.pc;

    ir_skid_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .din   (din),
        .count (count),
        .head  (head)
    );

    // Next state follows the occupancy expected after the coming edge.
    always_comb begin
        cnt_next = count;
        if (bus.flush)         cnt_next = 2'd0;
        else if (push && !pop) cnt_next = count + 2'd1;
        else if (!push && pop) cnt_next = count - 2'd1;
        occ_next = cnt_next + {1'b0, accept};

        state_next = S_RUN;
        if (bus.flush)                          state_next = inflight_reg ? S_DROP : S_IDLE;
        else if (occ_next == 2'd0)              state_next = S_IDLE;
        else if (occ_next == 2'(BUF_DEPTH))     state_next = S_FULL;
    end

    // Handshake enable, in-flight tracking, PC pairing and state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_reg <= 1'b0;
            inflight_reg <= 1'b0;
            pend_pc_reg  <= '0;
            state_reg    <= S_IDLE;
        end else begin
            ready_en_reg <= 1'b1;
            inflight_reg <= accept;
            if (accept) pend_pc_reg <= bus.pc_addr;
            state_reg    <= state_next;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of offered-but-refused PC cycles; flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= 16'd0;
        end else if (bus.pc_valid && !pc_ready_int && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed self-checking bench for instr_fetch_ir. Inputs change 1 time unit
// after the rising edge, outputs are checked 1 unit later.
module tb_instr_fetch_ir;
    import if_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_ir_if bus();

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_ir dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Instruction memory model: one-cycle synchronous read.
    logic [DATA_W-1:0] mem_arr [256];
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem_arr[bus.mem_addr] : 16'h0BAD;

    int tests_run    = 0;
    int tests_failed = 0;
    int acc;
    logic [7:0] cur;
    logic [7:0] a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = {~8'(i), 8'(i)};
        mem_arr[RESET_PC] = 16'hA5A5;

        // Reset held for three cycles with a valid PC offered
        rst          = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_addr  = RESET_PC;
        bus.ir_ready = 1'b1;
        bus.flush    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("rst_pc_ready", bus.pc_ready, 0);
            check("rst_mem_rd",   bus.mem_rd,   0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_ir_valid", bus.ir_valid, 0);
            check("rst_ir_data",  bus.ir_data,  0);
            check("rst_ir_pc",    bus.ir_pc,    0);
        end

        // Release; pc_ready comes up one cycle later
        cyc(); rst = 1'b1; bus.pc_valid = 1'b0; #1;
        check("rel_pc_ready", bus.pc_ready, 0);
        cyc(); bus.pc_valid = 1'b1; bus.pc_addr = RESET_PC; #1;
        check("first_pc_ready", bus.pc_ready, 1);
        check("first_mem_rd",   bus.mem_rd,   1);
        check("first_mem_addr", bus.mem_addr, 32'h80);
        cyc(); bus.pc_valid = 1'b0; #1;
        check("first_lat1_valid", bus.ir_valid, 0);
        cyc(); #1;
        check("first_ir_valid", bus.ir_valid, 1);
        check("first_ir_pc",    bus.ir_pc,    32'h80);
        check("first_ir_data",  bus.ir_data,  32'hA5A5);
        cyc(); #1;
        check("first_drained", bus.ir_valid, 0);

        // Streaming 80..87 with decode always ready
        for (int i = 0; i < 10; i++) begin
            cyc();
            bus.pc_valid = (i < 8);
            bus.pc_addr  = 8'(8'h80 + i);
            #1;
            if (i < 8) check("stream_pc_ready", bus.pc_ready, 1);
            if (i >= 2) begin
                a = 8'(8'h80 + i - 2);
                check("stream_ir_valid", bus.ir_valid, 1);
                check("stream_ir_pc",    bus.ir_pc,    32'(a));
                check("stream_ir_data",  bus.ir_data,  32'(mem_arr[a]));
            end
        end
        cyc(); bus.pc_valid = 1'b0; #1;
        check("stream_empty", bus.ir_valid, 0);

        // Backpressure: decode stalled, PC advances only on accept
        bus.ir_ready = 1'b0;
        acc = 0;
        cur = 8'h80;
        for (int i = 0; i < 6; i++) begin
            cyc();
            bus.pc_valid = 1'b1;
            bus.pc_addr  = cur;
            #1;
            if (bus.pc_ready) begin
                acc++;
                cur++;
            end
        end
        check("bp_accepts",  32'(acc),      2);
        check("bp_pc_ready", bus.pc_ready,  0);
        check("bp_ir_valid", bus.ir_valid,  1);
        check("bp_ir_pc",    bus.ir_pc,     32'h80);
        check("bp_ir_data",  bus.ir_data,   32'(mem_arr[8'h80]));
        cyc(); bus.ir_ready = 1'b1; bus.pc_addr = cur; #1;
        check("bp_resume_ready", bus.pc_ready, 1);
        check("bp_resume_addr",  bus.mem_addr, 32'h82);
        check("bp_drain0_pc",    bus.ir_pc,    32'h80);
        cyc(); bus.pc_valid = 1'b0; #1;
        check("bp_drain1_pc",   bus.ir_pc,   32'h81);
        check("bp_drain1_data", bus.ir_data, 32'(mem_arr[8'h81]));
        cyc(); #1;
        check("bp_drain2_valid", bus.ir_valid, 1);
        check("bp_drain2_pc",    bus.ir_pc,    32'h82);
        cyc(); #1;
        check("bp_empty", bus.ir_valid, 0);

        // Flush while the 90 fetch is in flight
        cyc(); bus.pc_valid = 1'b1; bus.pc_addr = 8'h90; #1;
        check("fl_accept_90", bus.pc_ready, 1);
        cyc(); bus.flush = 1'b1; bus.pc_addr = 8'h40; #1;
        check("fl_pc_ready", bus.pc_ready, 0);
        check("fl_mem_rd",   bus.mem_rd,   0);
        cyc(); bus.flush = 1'b0; #1;
        check("fl_drop_valid", bus.ir_valid, 0);
        check("fl_drop_ready", bus.pc_ready, 1);
        cyc(); bus.pc_valid = 1'b0; #1;
        check("fl_wait_valid", bus.ir_valid, 0);
        cyc(); #1;
        check("fl_ir_valid", bus.ir_valid, 1);
        check("fl_ir_pc",    bus.ir_pc,    32'h40);
        check("fl_ir_data",  bus.ir_data,  32'(mem_arr[8'h40]));
        cyc(); #1;
        check("fl_only_40", bus.ir_valid, 0);

        // Asynchronous reset with the buffer full
        cyc(); bus.ir_ready = 1'b0; bus.pc_valid = 1'b1; bus.pc_addr = 8'h10; #1;
        cyc(); bus.pc_addr = 8'h11; #1;
        cyc(); #1;
        cyc(); bus.ir_ready = 1'b1; bus.pc_addr = 8'h12; #1;
        check("ar_pre_valid", bus.ir_valid, 1);
        check("ar_pre_ready", bus.pc_ready, 1);
        check("ar_pre_mem_rd", bus.mem_rd,  1);
        #2; rst = 1'b0; #1;
        check("ar_ir_valid", bus.ir_valid, 0);
        check("ar_pc_ready", bus.pc_ready, 0);
        check("ar_mem_rd",   bus.mem_rd,   0);
        check("ar_ir_pc",    bus.ir_pc,    0);
        cyc(); #1;
        check("ar_held_valid", bus.ir_valid, 0);
        cyc(); rst = 1'b1; bus.pc_addr = 8'h20; #1;
        check("ar_rel_ready", bus.pc_ready, 0);
        cyc(); #1;
        check("ar_new_accept", bus.pc_ready, 1);
        check("ar_new_valid0", bus.ir_valid, 0);
        cyc(); bus.pc_valid = 1'b0; #1;
        check("ar_new_valid1", bus.ir_valid, 0);
        cyc(); #1;
        check("ar_new_ir_valid", bus.ir_valid, 1);
        check("ar_new_ir_pc",    bus.ir_pc,    32'h20);
        check("ar_new_ir_data",  bus.ir_data,  32'(mem_arr[8'h20]));

`ifdef IF_PERF_CNT_EN
        // Stall counter: 2 accepts, then 10 refused cycles
        cyc(); rst = 1'b0; bus.pc_valid = 1'b0; bus.ir_ready = 1'b0; #1;
        check("pc_rst_cnt", stall_cnt, 0);
        cyc(); rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            bus.pc_valid = 1'b1;
            bus.pc_addr  = 8'(8'h30 + i);
        end
        cyc(); bus.pc_valid = 1'b0; #1;
        check("pc_stall_cnt", stall_cnt, 10);
        cyc(); bus.flush = 1'b1;
        cyc(); bus.flush = 1'b0; #1;
        check("pc_after_flush", stall_cnt, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
